// File: rtl/visualizador_estado_pkg.sv
// rtl/visualizador_estado_pkg.sv - glyph codes and state codes for the alarm display
package visualizador_estado_pkg;

  localparam logic [3:0] G_0     = 4'd0;
  localparam logic [3:0] G_1     = 4'd1;
  localparam logic [3:0] G_2     = 4'd2;
  localparam logic [3:0] G_3     = 4'd3;
  localparam logic [3:0] G_4     = 4'd4;
  localparam logic [3:0] G_5     = 4'd5;
  localparam logic [3:0] G_6     = 4'd6;
  localparam logic [3:0] G_7     = 4'd7;
  localparam logic [3:0] G_8     = 4'd8;
  localparam logic [3:0] G_9     = 4'd9;
  localparam logic [3:0] G_E     = 4'd10;
  localparam logic [3:0] G_P     = 4'd11;
  localparam logic [3:0] G_L     = 4'd12;
  localparam logic [3:0] G_DASH  = 4'd13;
  localparam logic [3:0] G_BLANK = 4'd14;

  localparam logic [1:0] EST_INV = 2'b00;
  localparam logic [1:0] EST_0   = 2'b01;
  localparam logic [1:0] EST_1   = 2'b10;
  localparam logic [1:0] EST_2   = 2'b11;

  // State number shown after the 'E'; the invalid code shows a dash.
  function automatic logic [3:0] est_glyph(input logic [1:0] est);
    case (est)
      EST_0:   return G_0;
      EST_1:   return G_1;
      EST_2:   return G_2;
      default: return G_DASH;
    endcase
  endfunction

endpackage

// File: rtl/visualizador_estado_deco_7seg.sv
// rtl/visualizador_estado_deco_7seg.sv - glyph code to active-low {g,f,e,d,c,b,a}
module deco_7seg
  import visualizador_estado_pkg::*;
(
  input  logic [3:0] i_glyph,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    case (i_glyph)
      G_0:     o_seg = 7'b1000000;
      G_1:     o_seg = 7'b1111001;
      G_2:     o_seg = 7'b0100100;
      G_3:     o_seg = 7'b0110000;
      G_4:     o_seg = 7'b0011001;
      G_5:     o_seg = 7'b0010010;
      G_6:     o_seg = 7'b0000010;
      G_7:     o_seg = 7'b1111000;
      G_8:     o_seg = 7'b0000000;
      G_9:     o_seg = 7'b0010000;
      G_E:     o_seg = 7'b0000110;
      G_P:     o_seg = 7'b0001100;
      G_L:     o_seg = 7'b1000111;
      G_DASH:  o_seg = 7'b0111111;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/visualizador_estado.sv
// rtl/visualizador_estado.sv - 4-digit 7-segment display of alarm state, entry count and danger blink
module visualizador_estado
  import visualizador_estado_pkg::*;
#(
  parameter int REFRESH_W = 18,
  parameter int BLINK_W   = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       EN_7,
  input  logic [1:0] estado,
  input  logic       led_pelig,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam logic [REFRESH_W-1:0] SCAN_ONE  = 1;
  localparam logic [BLINK_W-1:0]   BLINK_ONE = 1;

  logic                 r_en_q;
  logic [1:0]           r_est_q;
  logic [1:0]           r_est_p;
  logic                 r_pel_q;
  logic [REFRESH_W-1:0] r_scan;
  logic [BLINK_W-1:0]   r_blink;
  logic [3:0]           r_dec;
  logic [3:0]           r_uni;
  logic [3:0]           r_an;
  logic [6:0]           r_seg;

  logic [1:0] w_sel;
  logic [3:0] w_glyph;
  logic [6:0] w_seg;
  logic [3:0] w_an;
  logic       w_dark;
  logic       w_entry;

  assign w_sel   = r_scan[REFRESH_W-1 -: 2];
  assign w_an    = ~(4'b0001 << w_sel);
  assign w_dark  = ~r_en_q | (r_pel_q & r_blink[BLINK_W-1]);
  assign w_entry = (r_est_q == EST_1) && (r_est_p != EST_1);

  always_comb begin
    w_glyph = G_BLANK;
    case (w_sel)
      2'd3: w_glyph = r_pel_q ? G_P : G_E;
      2'd2: w_glyph = r_pel_q ? G_E : est_glyph(r_est_q);
      2'd1: w_glyph = r_pel_q ? G_L : r_dec;
      2'd0: w_glyph = r_pel_q ? G_1 : r_uni;
      default: w_glyph = G_BLANK;
    endcase
  end

  deco_7seg u_deco (
    .i_glyph (w_glyph),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en_q  <= 1'b0;
      r_est_q <= 2'b00;
      r_est_p <= 2'b00;
      r_pel_q <= 1'b0;
      r_scan  <= '0;
      r_blink <= '0;
      r_dec   <= 4'd0;
      r_uni   <= 4'd0;
      r_an    <= 4'b1111;
      r_seg   <= 7'b1111111;
    end else begin
      r_en_q  <= EN_7;
      r_est_q <= estado;
      r_est_p <= r_est_q;
      r_pel_q <= led_pelig;
      r_scan  <= r_scan + SCAN_ONE;
      // Restart the blink on a fresh alarm so PELI is always lit first.
      r_blink <= (led_pelig && !r_pel_q) ? '0 : r_blink + BLINK_ONE;

      if (w_entry) begin
        if (r_uni == 4'd9) begin
          r_uni <= 4'd0;
          r_dec <= (r_dec == 4'd9) ? 4'd0 : r_dec + 4'd1;
        end else begin
          r_uni <= r_uni + 4'd1;
        end
      end

      if (w_dark) begin
        r_an  <= 4'b1111;
        r_seg <= 7'b1111111;
      end else begin
        r_an  <= w_an;
        r_seg <= w_seg;
      end
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule
